// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: scheduler state encoding, FP32 constants,
// rounding-mode encodings and lane-select helpers for packed requester buses.
package fp32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    // Requester i owns bits [32i+31:32i] of a packed operand bus.
    function automatic logic [31:0] lane32(input logic [63:0] v, input logic sel);
        return sel ? v[63:32] : v[31:0];
    endfunction

    function automatic logic [1:0] lane2(input logic [3:0] v, input logic sel);
        return sel ? v[3:2] : v[1:0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/fp32_add_sched.sv
// Time-shares one combinational FP32 adder between two requesters: grant,
// register operands, wait ADD_LAT cycles, capture, and return the result.
module fp32_add_sched
    import fp32_pkg::*;
#(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [3:0]  req_rmode,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_y,
    output logic        rsp_error,
    output logic        rsp_overflow,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic [1:0]  add_rmode,
    input  logic [31:0] add_y,
    input  logic        add_error,
    input  logic        add_overflow,
    output logic        busy
);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        add_a_q, add_a_d;
    logic [31:0]        add_b_q, add_b_d;
    logic [1:0]         add_rmode_q, add_rmode_d;
    logic [31:0]        rsp_y_q, rsp_y_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_ovf_q, rsp_ovf_d;
    logic [1:0]         gnt;
    logic [1:0]         req_ready_c;
    logic [1:0]         rsp_valid_c;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_q),
        .gnt  (gnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_rmode_d = add_rmode_q;
        rsp_y_d     = rsp_y_q;
        rsp_err_d   = rsp_err_q;
        rsp_ovf_d   = rsp_ovf_q;
        req_ready_c = 2'b00;
        rsp_valid_c = 2'b00;

        unique case (state_q)
            IDLE: begin
                req_ready_c = gnt;
                if (gnt != 2'b00) begin
                    add_a_d     = lane32(req_a, gnt[1]);
                    add_b_d     = lane32(req_b, gnt[1]);
                    add_rmode_d = lane2(req_rmode, gnt[1]);
                    owner_d     = gnt[1];
                    last_d      = gnt[1];
                    cnt_d       = CNT_W'(ADD_LAT - 1);
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_y_d   = add_y;
                    rsp_err_d = add_error;
                    rsp_ovf_d = add_overflow;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid_c[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_rmode_q <= '0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_rmode_q <= add_rmode_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    // The grant is combinational from req_valid, so it is masked while reset is held.
    assign req_ready    = rst_n ? req_ready_c : 2'b00;
    assign rsp_valid    = rsp_valid_c;
    assign rsp_y        = rsp_y_q;
    assign rsp_error    = rsp_err_q;
    assign rsp_overflow = rsp_ovf_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign add_rmode    = add_rmode_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fp32_add_sched.sv
// Bench for fp32_add_sched: a slow stand-in adder, a response scoreboard and
// directed steps covering arbitration, back-pressure, overflow and reset abort.
module tb_fp32_add_sched;
    import fp32_pkg::*;

    localparam int LAT = 3;

    typedef struct packed {
        logic [31:0] y;
        logic        err;
        logic        ovf;
    } res_t;

    typedef struct {
        logic idx;
        res_t res;
        int   acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_rmode;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_y;
    logic        rsp_error, rsp_overflow;
    logic [31:0] add_a, add_b, add_y;
    logic [1:0]  add_rmode;
    logic        add_error, add_overflow;
    logic        busy;

    always #5 clk = ~clk;

    fp32_add_sched #(.ADD_LAT(LAT), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_rmode    (req_rmode),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_error    (rsp_error),
        .rsp_overflow (rsp_overflow),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_rmode    (add_rmode),
        .add_y        (add_y),
        .add_error    (add_error),
        .add_overflow (add_overflow),
        .busy         (busy)
    );

    // Reference results for the operand pairs used here; other pairs map to a^b.
    function automatic res_t add_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] rm);
        res_t r;
        r = '0;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) begin
            r.y   = FP32_QNAN;
            r.err = 1'b1;
        end else if (a == FP32_ONE && b == 32'h4000_0000) begin
            r.y = 32'h4040_0000;
        end else if (a == FP32_ONE && b == FP32_ONE) begin
            r.y = 32'h4000_0000;
        end else if (a == 32'h4000_0000 && b == 32'h4000_0000) begin
            r.y = 32'h4080_0000;
        end else if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) begin
            r.ovf = 1'b1;
            r.y   = (rm == RM_RTZ || rm == RM_RDN) ? 32'h7F7F_FFFF : 32'h7F80_0000;
        end else begin
            r.y = a ^ b;
        end
        return r;
    endfunction

    // The adder only settles in the last evaluation cycle; before that it shows inverted garbage.
    logic [3:0] exec_cyc;
    res_t       live;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         exec_cyc <= 4'd0;
        else if ((req_valid & req_ready) != 2'b00) exec_cyc <= 4'd1;
        else if (exec_cyc != 4'd0 && exec_cyc < 4'(LAT)) exec_cyc <= exec_cyc + 4'd1;
        else                                exec_cyc <= 4'd0;
    end

    assign live         = add_model(add_a, add_b, add_rmode);
    assign add_y        = (exec_cyc == 4'(LAT)) ? live.y   : ~live.y;
    assign add_error    = (exec_cyc == 4'(LAT)) ? live.err : ~live.err;
    assign add_overflow = (exec_cyc == 4'(LAT)) ? live.ovf : ~live.ovf;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rsp_count = 0;
    exp_t sb[$];
    int   acc_idx[$];
    int   acc_cyc_q[$];
    int   quota[2];
    logic [1:0] drop_pend;
    logic [1:0] pending_prev;
    bit   first_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: sample handshakes and responses mid-cycle, then advance to the next negedge.
    task automatic step();
        exp_t e;
        #1;
        assert ((pending_prev & ~req_valid) == 2'b00)
            else $error("stimulus rule broken: pending req_valid withdrawn");
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.idx     = i[0];
                e.res     = add_model(req_a[32*i +: 32], req_b[32*i +: 32], req_rmode[2*i +: 2]);
                e.acc_cyc = cyc;
                sb.push_back(e);
                acc_idx.push_back(i);
                acc_cyc_q.push_back(cyc);
                if (quota[i] > 0) begin
                    quota[i]--;
                    if (quota[i] == 0) drop_pend[i] = 1'b1;
                end
            end
        end
        pending_prev = req_valid & ~req_ready;
        if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb[0];
                chk("rsp_valid", 32'(rsp_valid), 32'(2'b01) << e.idx);
                chk("rsp_y", rsp_y, e.res.y);
                chk("rsp_error", 32'(rsp_error), 32'(e.res.err));
                chk("rsp_overflow", 32'(rsp_overflow), 32'(e.res.ovf));
                if (!first_seen) begin
                    chk("rsp_latency", cyc - e.acc_cyc, LAT + 1);
                    first_seen = 1'b1;
                end
                if (rsp_ready[e.idx]) begin
                    void'(sb.pop_front());
                    first_seen = 1'b0;
                    rsp_count++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (drop_pend[i]) begin
                req_valid[i] = 1'b0;
                drop_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((busy || sb.size() != 0 || req_valid != 2'b00) && n < max) begin
            step();
            n++;
        end
        chk(tag, 32'(n >= max), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        first_seen   = 1'b0;
        pending_prev = 2'b00;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        acc_idx.delete();
        acc_cyc_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rel_cyc;
        logic [31:0] held_y;

        rst_n        = 1'b0;
        req_valid    = 2'b00;
        req_a        = '0;
        req_b        = '0;
        req_rmode    = '0;
        rsp_ready    = 2'b00;
        quota[0]     = 0;
        quota[1]     = 0;
        drop_pend    = 2'b00;
        pending_prev = 2'b00;
        first_seen   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_b", add_b, 32'd0);
        chk("rst_add_rmode", 32'(add_rmode), 32'd0);
        chk("rst_rsp_y", rsp_y, 32'd0);
        chk("rst_rsp_flags", 32'({rsp_error, rsp_overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 0: 1.0 + 2.0
        clear_log();
        req_a[31:0]    = FP32_ONE;
        req_b[31:0]    = 32'h4000_0000;
        req_rmode[1:0] = RM_RNE;
        rsp_ready      = 2'b01;
        quota[0]       = 1;
        req_valid      = 2'b01;
        wait_idle("t1_timeout", 40);
        chk("t1_accepts", acc_idx.size(), 1);
        chk("t1_owner", acc_idx[0], 0);

        // Both requesters continuously valid from reset: strict alternation
        do_reset();
        clear_log();
        req_a     = {32'h4000_0000, FP32_ONE};
        req_b     = {32'h4000_0000, FP32_ONE};
        req_rmode = {RM_RTZ, RM_RNE};
        rsp_ready = 2'b11;
        quota[0]  = 2;
        quota[1]  = 2;
        req_valid = 2'b11;
        wait_idle("t2_timeout", 100);
        chk("t2_accepts", acc_idx.size(), 4);
        for (int k = 0; k < 4; k++) chk("t2_grant_order", acc_idx[k], k % 2);
        for (int k = 0; k < 3; k++) chk("t2_interval", acc_cyc_q[k+1] - acc_cyc_q[k], LAT + 2);

        // Back-pressure on requester 1 while requester 0 waits
        clear_log();
        req_a     = {FP32_ONE, FP32_ONE};
        req_b     = {32'h4000_0000, FP32_ONE};
        req_rmode = {RM_RNE, RM_RNE};
        rsp_ready = 2'b01;
        quota[1]  = 1;
        req_valid = 2'b10;
        n = 0;
        while (acc_idx.size() == 0 && n < 20) begin step(); n++; end
        chk("t3_accept_timeout", 32'(n >= 20), 32'd0);
        quota[0]     = 1;
        req_valid[0] = 1'b1;
        n = 0;
        while (!rsp_valid[1] && n < 20) begin step(); n++; end
        chk("t3_rsp_timeout", 32'(n >= 20), 32'd0);
        held_y = add_model(FP32_ONE, 32'h4000_0000, RM_RNE).y;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_hold_valid", 32'(rsp_valid), 32'd2);
            chk("t3_hold_y", rsp_y, held_y);
            chk("t3_hold_busy", 32'(busy), 32'd1);
            chk("t3_hold_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 2'b11;
        rel_cyc   = cyc;
        wait_idle("t3_timeout", 40);
        chk("t3_accepts", acc_idx.size(), 2);
        chk("t3_second_owner", acc_idx[1], 0);
        chk("t3_release_grant", acc_cyc_q[1] - rel_cyc, 1);

        // Overflow passes straight through, then a normal operation
        clear_log();
        req_a[31:0]    = 32'h7F7F_FFFF;
        req_b[31:0]    = 32'h7F7F_FFFF;
        req_rmode[1:0] = RM_RNE;
        quota[0]       = 1;
        req_valid      = 2'b01;
        wait_idle("t4_ovf_timeout", 40);
        req_a[63:32]   = FP32_ONE;
        req_b[63:32]   = FP32_ONE;
        req_rmode[3:2] = RM_RUP;
        quota[1]       = 1;
        req_valid      = 2'b10;
        wait_idle("t4_next_timeout", 40);
        chk("t4_accepts", acc_idx.size(), 2);

        // Reset during EXEC discards the operation
        clear_log();
        req_a[63:32] = FP32_ONE;
        req_b[63:32] = 32'h4000_0000;
        quota[1]     = 1;
        req_valid    = 2'b10;
        n = 0;
        while (acc_idx.size() == 0 && n < 20) begin step(); n++; end
        chk("t5_accept_timeout", 32'(n >= 20), 32'd0);
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_add_a", add_a, 32'd0);
        chk("t5_rst_add_b", add_b, 32'd0);
        chk("t5_rst_add_rmode", 32'(add_rmode), 32'd0);
        chk("t5_rst_rsp_y", rsp_y, 32'd0);
        chk("t5_rst_flags", 32'({rsp_error, rsp_overflow}), 32'd0);
        sb.delete();
        first_seen   = 1'b0;
        pending_prev = 2'b00;
        req_valid    = 2'b00;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        clear_log();
        req_a     = {32'h4000_0000, FP32_ONE};
        req_b     = {32'h4000_0000, FP32_ONE};
        quota[0]  = 1;
        quota[1]  = 1;
        req_valid = 2'b11;
        wait_idle("t5_timeout", 60);
        chk("t5_accepts", acc_idx.size(), 2);
        chk("t5_first_grant", acc_idx[0], 0);

        chk("total_responses", rsp_count, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
